// File: rtl/button_event_if.sv
// Button-event bundle: one debounced level in, classified click/press events out.
// master drives the button level, slave is the classifier.
interface button_event_if;
  logic       stable;
  logic       single_click;
  logic       double_click;
  logic       long_press;
  logic       held;
  logic [7:0] click_count;

  modport master (
    output stable,
    input  single_click, double_click, long_press, held, click_count
  );

  modport slave (
    input  stable,
    output single_click, double_click, long_press, held, click_count
  );
endinterface

// File: rtl/button_event.sv
// Classifies a debounced button level into single click, double click and
// long press pulses, and keeps a wrapping count of click events.
module button_event #(
  parameter int LONG_CYCLES = 1000,
  parameter int GAP_CYCLES  = 250
) (
  input logic           clk,
  input logic           rst,
  button_event_if.slave bus
);

  localparam int MAXC = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONGHELD} state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic          prev;
  logic          rise, fall;
  logic          single_nxt, double_nxt, long_nxt;
  logic          single_q, double_q, long_q;
  logic [7:0]    click_count_q;

  assign rise = bus.stable & ~prev;
  assign fall = ~bus.stable & prev;

  // Edges win over timeouts, so a rise landing on the last gap cycle is a second press.
  always_comb begin
    next_state = state;
    single_nxt = 1'b0;
    double_nxt = 1'b0;
    long_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) next_state = PRESS1;
      end
      PRESS1: begin
        if (fall) begin
          next_state = WAIT2;
        end else if (cnt == CW'(LONG_CYCLES - 1)) begin
          next_state = LONGHELD;
          long_nxt   = 1'b1;
        end
      end
      WAIT2: begin
        if (rise) begin
          next_state = PRESS2;
        end else if (cnt == CW'(GAP_CYCLES - 1)) begin
          next_state = IDLE;
          single_nxt = 1'b1;
        end
      end
      PRESS2: begin
        if (fall) begin
          next_state = IDLE;
          double_nxt = 1'b1;
        end
      end
      LONGHELD: begin
        if (fall) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The counter restarts on every state change so each timed state measures from its entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      prev          <= 1'b0;
      single_q      <= 1'b0;
      double_q      <= 1'b0;
      long_q        <= 1'b0;
      click_count_q <= 8'd0;
    end else begin
      state    <= next_state;
      prev     <= bus.stable;
      single_q <= single_nxt;
      double_q <= double_nxt;
      long_q   <= long_nxt;
      if (next_state != state) begin
        cnt <= '0;
      end else if (state == PRESS1 || state == WAIT2) begin
        cnt <= cnt + 1'b1;
      end
      if (single_nxt || double_nxt) begin
        click_count_q <= click_count_q + 8'd1;
      end
    end
  end

  assign bus.single_click = single_q;
  assign bus.double_click = double_q;
  assign bus.long_press   = long_q;
  assign bus.held         = prev;
  assign bus.click_count  = click_count_q;

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event with LONG_CYCLES=20, GAP_CYCLES=8: stimulus
// queues expected events, a negedge monitor pops and compares each pulse.
module tb_button_event;

  localparam int LONG = 20;
  localparam int GAP  = 8;
  localparam int K_SINGLE = 0;
  localparam int K_DOUBLE = 1;
  localparam int K_LONG   = 2;

  typedef struct {
    int kind;
    int edge_no;
    int count;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   exp_count = 0;
  logic exp_held = 1'b0;
  exp_t sb[$];

  button_event_if bus ();

  button_event #(.LONG_CYCLES(LONG), .GAP_CYCLES(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    exp_held <= rst ? 1'b0 : bus.stable;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, cyc);
    end
  endtask

  // Hold the button level (with current rst) for n clock edges; returns just after the last edge.
  task automatic applyStimulus(input logic lvl, input int n);
    bus.stable = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectEvent(input int kind, input int edge_no, input int count);
    exp_t e;
    e.kind    = kind;
    e.edge_no = edge_no;
    e.count   = count;
    sb.push_back(e);
  endtask

  // Monitor: every pulse must match the head of the scoreboard; late heads count as missed.
  always @(negedge clk) begin
    int   npulse;
    int   kind;
    exp_t e;
    if (cyc >= 1) begin
      checkOutput("held", int'(bus.held), int'(exp_held));
      npulse = int'(bus.single_click) + int'(bus.double_click) + int'(bus.long_press);
      kind   = bus.double_click ? K_DOUBLE : (bus.long_press ? K_LONG : K_SINGLE);
      if (npulse > 1) begin
        checkOutput("pulses_onehot", npulse, 1);
      end
      if (npulse >= 1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_pulse_kind", kind, -1);
        end else begin
          e = sb.pop_front();
          checkOutput("event_kind", kind, e.kind);
          checkOutput("event_edge", cyc, e.edge_no);
          checkOutput("event_count", int'(bus.click_count), e.count);
        end
      end else if (sb.size() > 0 && cyc > sb[0].edge_no) begin
        e = sb.pop_front();
        checkOutput("missed_event_edge", cyc, e.edge_no);
      end
    end
  end

  initial begin
    int f;
    int r;
    bus.stable = 1'b1;
    rst = 1'b1;
    applyStimulus(1'b1, 3);
    checkOutput("reset_held", int'(bus.held), 0);
    checkOutput("reset_count", int'(bus.click_count), 0);
    checkOutput("reset_pulses", int'(bus.single_click | bus.double_click | bus.long_press), 0);
    rst = 1'b0;
    applyStimulus(1'b0, 4);

    // Single click: high 5, low 10, single_click 8 edges after the fall.
    applyStimulus(1'b1, 5);
    f = cyc + 1;
    exp_count++;
    expectEvent(K_SINGLE, f + GAP, exp_count);
    applyStimulus(1'b0, 10);

    // Double click: high 3, low 4, high 3, low.
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 4);
    applyStimulus(1'b1, 3);
    f = cyc + 1;
    exp_count++;
    expectEvent(K_DOUBLE, f, exp_count);
    applyStimulus(1'b0, 12);

    // Long press: high 30, then release without any click.
    r = cyc + 1;
    expectEvent(K_LONG, r + LONG, exp_count);
    applyStimulus(1'b1, 30);
    applyStimulus(1'b0, 12);

    // One-cycle glitch is a valid short press.
    applyStimulus(1'b1, 1);
    f = cyc + 1;
    exp_count++;
    expectEvent(K_SINGLE, f + GAP, exp_count);
    applyStimulus(1'b0, 12);

    // Second rise exactly on the 8th edge after the fall becomes a double click.
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, GAP);
    applyStimulus(1'b1, 2);
    f = cyc + 1;
    exp_count++;
    expectEvent(K_DOUBLE, f, exp_count);
    applyStimulus(1'b0, 12);

    // Rise on the 9th edge: single click first, then a fresh press.
    applyStimulus(1'b1, 2);
    f = cyc + 1;
    exp_count++;
    expectEvent(K_SINGLE, f + GAP, exp_count);
    applyStimulus(1'b0, GAP + 1);
    applyStimulus(1'b1, 2);
    f = cyc + 1;
    exp_count++;
    expectEvent(K_SINGLE, f + GAP, exp_count);
    applyStimulus(1'b0, 12);

    // Reset mid-press: nothing from the first press, post-reset high is a new press.
    applyStimulus(1'b1, 10);
    rst = 1'b1;
    applyStimulus(1'b1, 1);
    checkOutput("midreset_count", int'(bus.click_count), 0);
    rst = 1'b0;
    exp_count = 0;
    r = cyc + 1;
    expectEvent(K_LONG, r + LONG, exp_count);
    applyStimulus(1'b1, 29);
    applyStimulus(1'b0, 12);

    // Wrap: 256 single clicks bring the count back to zero.
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 1);
      f = cyc + 1;
      exp_count = (exp_count + 1) % 256;
      expectEvent(K_SINGLE, f + GAP, exp_count);
      applyStimulus(1'b0, 10);
    end

    for (int w = 0; w < 50 && sb.size() > 0; w++) begin
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b0, 2);
    checkOutput("scoreboard_empty", sb.size(), 0);
    checkOutput("final_count", int'(bus.click_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameter: LONG_CYCLES, default 1000, hold length in clocks that classifies a press as long; SHALL be >= 2.
REQ-002 Parameter: GAP_CYCLES, default 250, maximum release-to-press gap in clocks that still counts as a double click; SHALL be >= 2.
REQ-003 Port: clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: stable  input  1  debounced, synchronized button level, high = pressed.
REQ-006 Port: single_click  output  1  one-cycle pulse: short press with no second press inside the gap.
REQ-007 Port: double_click  output  1  one-cycle pulse: second short press released.
REQ-008 Port: long_press  output  1  one-cycle pulse: first press held for LONG_CYCLES.
REQ-009 Port: held  output  1  registered copy of stable, one-cycle delay.
REQ-010 Port: click_count  output  8  count of single_click plus double_click events; wraps 255 -> 0.

Function
REQ-011 A previous-sample register prev SHALL hold last cycle's stable; rise = stable & !prev, fall = !stable & prev.
REQ-012 The FSM SHALL have exactly five states: IDLE, PRESS1, WAIT2, PRESS2, LONGHELD.
REQ-013 One counter cnt, width $clog2(max(LONG_CYCLES,GAP_CYCLES)+1), SHALL clear on every state change and otherwise increment once per clock in PRESS1 and WAIT2.
REQ-014 IDLE: on rise, go to PRESS1; otherwise stay.
REQ-015 PRESS1: on fall, go to WAIT2; else when cnt == LONG_CYCLES-1, go to LONGHELD and pulse long_press.
REQ-016 PRESS1 timing: with the rise sampled at edge k and stable high at every edge through k+LONG_CYCLES, long_press SHALL be high only in the cycle after edge k+LONG_CYCLES.
REQ-017 LONGHELD: on fall, go to IDLE; no click pulse is issued and click_count is unchanged.
REQ-018 WAIT2: on rise, go to PRESS2; else when cnt == GAP_CYCLES-1, pulse single_click and go to IDLE.
REQ-019 WAIT2 simultaneous case: a rise on the same edge as cnt == GAP_CYCLES-1 SHALL take the rise (PRESS2); no single_click is issued.
REQ-020 PRESS2: on fall, pulse double_click and go to IDLE, regardless of hold length; long_press is never issued from PRESS2.
REQ-021 All pulse outputs SHALL be registered and high for exactly one cycle; at most one of the three SHALL be high in any cycle.
REQ-022 click_count SHALL increment in the same clock edge that sets single_click or double_click.
REQ-023 Behaviour SHALL be cycle-exact for any input sequence, including glitches of one cycle (a 1-cycle high is a valid short press).

Reset
REQ-024 When rst is high at a clock edge: state = IDLE, cnt = 0, prev = 0, held = 0, click_count = 0, and all pulse outputs = 0.
REQ-025 Reset SHALL override any in-progress classification; no pulse SHALL be produced from pre-reset activity.
REQ-026 If stable is high on the first edge after reset release, it SHALL be treated as a rise (prev reset = 0).

Verification (LONG_CYCLES=20, GAP_CYCLES=8)
REQ-027 Single click: stable high 5 cycles, then low 10 -> exactly one single_click, 8 cycles after the fall edge; click_count = 1.
REQ-028 Double click: high 3, low 4, high 3, low -> one double_click the cycle after the second fall; no single_click; click_count = 1.
REQ-029 Long press: high 30 cycles -> one long_press exactly 20 edges after the rise edge; after the release no click pulse; click_count = 0.
REQ-030 Gap boundary: release, then rise on exactly the 8th edge after the fall -> PRESS2, no single_click; rise on the 9th edge -> single_click, then a new PRESS1.
REQ-031 Reset mid-operation: hold 10 cycles, assert rst for 1 cycle, keep stable high -> no pulse from the first press; the post-reset high is a new press, and long_press fires 20 edges after reset release.
REQ-032 Wrap: 256 single clicks -> click_count returns to 0; the pulse count per click is always exactly 1.
